// File: rtl/sample_sequencer_pkg.sv
// Shared state codes, field widths and azmux code lookup for the sample sequencer.
// Pure definitions: no latency and no backpressure.
package sample_sequencer_pkg;

    localparam int N_CH = 4;
    localparam int CH_W = 2;
    localparam int AZ_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_TRIG   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    function automatic logic [AZ_W-1:0] azmux_code(input logic [N_CH*AZ_W-1:0] codes,
                                                   input logic [CH_W-1:0]      idx);
        return codes[idx*AZ_W +: AZ_W];
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Clear/enable saturating up-counter with an equality compare against a live limit.
// hit is combinational from the count register; no backpressure.
module seq_timer #(
    parameter int W             = 24,
    parameter bit ZERO_DISABLES = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         hit
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

    // A zero limit means "no limit" for the timeout instance.
    assign hit = (cnt == limit) && !(ZERO_DISABLES && (limit == '0));

endmodule

// File: rtl/sample_sequencer.sv
// Walks the azmux through the channel list, settling then triggering the ADC per sample.
// All outputs registered from next state; first trig 2+settle cycles after the arm edge; ADC paced by valid edges.
module sample_sequencer
    import sample_sequencer_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int SETTLE_W = 24,
    parameter int TMO_W    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arm_i,
    input  logic [CH_W-1:0]        p_seq_len_i,
    input  logic [N_CH*AZ_W-1:0]   p_azmux_ch_i,
    input  logic [CNT_W-1:0]       p_samples_per_ch_i,
    input  logic [SETTLE_W-1:0]    p_clk_count_settle_i,
    input  logic [TMO_W-1:0]       p_clk_count_timeout_i,
    input  logic                   adc_measure_valid_i,
    output logic                   adc_measure_trig_o,
    output logic [AZ_W-1:0]        azmux_o,
    output logic                   meas_complete_o,
    output logic                   spi_interrupt_o,
    output logic                   error_o,
    output logic [2:0]             status_o,
    output logic [CH_W-1:0]        ch_idx_o,
    output logic [CNT_W-1:0]       sample_count_o
);

    state_t           state_q, state_d;
    logic             arm_q, valid_q;
    logic             settle_hit, tmo_hit;
    logic             arm_rise, valid_rise, last_sample, more_ch;
    logic [CNT_W-1:0] spc, sc_inc, sc_d;
    logic [CH_W-1:0]  ch_d;
    logic [AZ_W-1:0]  az_d;
    logic             trig_d, done_d, err_d, irq_d;

    assign arm_rise    = arm_i && !arm_q;
    assign valid_rise  = adc_measure_valid_i && !valid_q;
    assign spc         = (p_samples_per_ch_i == '0) ? CNT_W'(1) : p_samples_per_ch_i;
    assign sc_inc      = (sample_count_o == '1) ? sample_count_o : sample_count_o + CNT_W'(1);
    // Widened by one bit so a saturated count still compares correctly.
    assign last_sample = ({1'b0, sample_count_o} + (CNT_W+1)'(1)) >= {1'b0, spc};
    assign more_ch     = ch_idx_o < p_seq_len_i;
    assign status_o    = state_q;

    seq_timer #(.W(SETTLE_W), .ZERO_DISABLES(1'b0)) u_settle (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q != ST_SETTLE),
        .en    (state_q == ST_SETTLE),
        .limit (p_clk_count_settle_i),
        .hit   (settle_hit)
    );

    seq_timer #(.W(TMO_W), .ZERO_DISABLES(1'b1)) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q != ST_WAIT),
        .en    (state_q == ST_WAIT),
        .limit (p_clk_count_timeout_i),
        .hit   (tmo_hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (arm_rise) state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (!arm_i)          state_d = ST_IDLE;
                else if (settle_hit) state_d = ST_TRIG;
            end
            ST_TRIG:   state_d = arm_i ? ST_WAIT : ST_IDLE;
            ST_WAIT: begin
                // A valid edge beats a timeout in the same cycle.
                if (!arm_i)            state_d = ST_IDLE;
                else if (valid_rise) begin
                    if (!last_sample)  state_d = ST_TRIG;
                    else if (more_ch)  state_d = ST_SETTLE;
                    else               state_d = ST_DONE;
                end else if (tmo_hit)  state_d = ST_ERR;
            end
            ST_DONE, ST_ERR: if (!arm_i) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ch_d   = ch_idx_o;
        sc_d   = sample_count_o;
        az_d   = azmux_o;
        trig_d = (state_d == ST_TRIG);
        done_d = (state_d == ST_DONE);
        err_d  = (state_d == ST_ERR);
        irq_d  = (state_d != state_q) && ((state_d == ST_DONE) || (state_d == ST_ERR));
        case (state_q)
            ST_IDLE: begin
                if (state_d == ST_SETTLE) begin
                    ch_d = '0;
                    sc_d = '0;
                    az_d = azmux_code(p_azmux_ch_i, '0);
                end
            end
            ST_SETTLE, ST_TRIG: begin
                if (state_d == ST_IDLE) begin
                    ch_d = '0;
                    sc_d = '0;
                end
            end
            ST_WAIT: begin
                if (state_d == ST_IDLE) begin
                    ch_d = '0;
                    sc_d = '0;
                end else if (state_d == ST_SETTLE) begin
                    ch_d = ch_idx_o + CH_W'(1);
                    sc_d = '0;
                    az_d = azmux_code(p_azmux_ch_i, ch_idx_o + CH_W'(1));
                end else if (valid_rise) begin
                    sc_d = sc_inc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            arm_q              <= 1'b0;
            valid_q            <= 1'b0;
            adc_measure_trig_o <= 1'b0;
            azmux_o            <= '0;
            meas_complete_o    <= 1'b0;
            spi_interrupt_o    <= 1'b0;
            error_o            <= 1'b0;
            ch_idx_o           <= '0;
            sample_count_o     <= '0;
        end else begin
            arm_q              <= arm_i;
            valid_q            <= adc_measure_valid_i;
            adc_measure_trig_o <= trig_d;
            azmux_o            <= az_d;
            meas_complete_o    <= done_d;
            spi_interrupt_o    <= irq_d;
            error_o            <= err_d;
            ch_idx_o           <= ch_d;
            sample_count_o     <= sc_d;
        end
    end

endmodule

// File: tb/tb_sample_sequencer.sv
// Scenario bench for sample_sequencer: per-feature tasks plus a monitor that scores every
// trigger (against the expected azmux code) and every interrupt (against the expected state).
module tb_sample_sequencer;
    import sample_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        arm = 1'b0;
    logic [1:0]  seq_len = '0;
    logic [15:0] codes = '0;
    logic [15:0] samples = '0;
    logic [23:0] settle = '0;
    logic [31:0] tmo = '0;
    logic        valid = 1'b0;

    logic        trig_o, complete_o, irq_o, error_o;
    logic [3:0]  azmux_o;
    logic [2:0]  status_o;
    logic [1:0]  ch_idx_o;
    logic [15:0] sample_count_o;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    logic [3:0] trig_q[$];
    logic [2:0] irq_q[$];

    sample_sequencer dut (
        .clk                   (clk),
        .reset                 (reset),
        .arm_i                 (arm),
        .p_seq_len_i           (seq_len),
        .p_azmux_ch_i          (codes),
        .p_samples_per_ch_i    (samples),
        .p_clk_count_settle_i  (settle),
        .p_clk_count_timeout_i (tmo),
        .adc_measure_valid_i   (valid),
        .adc_measure_trig_o    (trig_o),
        .azmux_o               (azmux_o),
        .meas_complete_o       (complete_o),
        .spi_interrupt_o       (irq_o),
        .error_o               (error_o),
        .status_o              (status_o),
        .ch_idx_o              (ch_idx_o),
        .sample_count_o        (sample_count_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (trig_o) begin
            total_cnt++;
            if (trig_q.size() == 0) $display("FAIL unexpected_trig cycle=%0d azmux=%h", cyc, azmux_o);
            else begin
                logic [3:0] exp_az;
                exp_az = trig_q.pop_front();
                if (azmux_o !== exp_az) $display("FAIL trig_azmux cycle=%0d got=%h exp=%h", cyc, azmux_o, exp_az);
                else pass_cnt++;
            end
        end
        if (irq_o) begin
            total_cnt++;
            if (irq_q.size() == 0) $display("FAIL unexpected_irq cycle=%0d status=%0d", cyc, status_o);
            else begin
                logic [2:0] exp_st;
                exp_st = irq_q.pop_front();
                if (status_o !== exp_st) $display("FAIL irq_state cycle=%0d got=%0d exp=%0d", cyc, status_o, exp_st);
                else pass_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, got cycle=%0d exp=<50000", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wait_trig(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (trig_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic set_params(input logic [1:0] l, input logic [15:0] c, input logic [15:0] s,
                              input logic [23:0] st, input logic [31:0] t);
        seq_len = l; codes = c; samples = s; settle = st; tmo = t;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++; if (status_o !== 3'd0) $display("FAIL rst_status got=%0d exp=0", status_o); else pass_cnt++;
        total_cnt++; if (trig_o !== 1'b0) $display("FAIL rst_trig got=%b exp=0", trig_o); else pass_cnt++;
        total_cnt++; if (azmux_o !== 4'h0) $display("FAIL rst_azmux got=%h exp=0", azmux_o); else pass_cnt++;
        total_cnt++; if ({complete_o, irq_o, error_o} !== 3'b000) $display("FAIL rst_flags got=%b exp=000", {complete_o, irq_o, error_o}); else pass_cnt++;
        total_cnt++; if ({ch_idx_o, sample_count_o} !== 18'd0) $display("FAIL rst_counts got=%h exp=0", {ch_idx_o, sample_count_o}); else pass_cnt++;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (status_o !== ST_IDLE) $display("FAIL rst_idle got=%0d exp=%0d", status_o, ST_IDLE); else pass_cnt++;
    endtask

    task automatic test_single_channel;
        int a0, t1, t2;
        bit ok;
        set_params(2'd0, 16'h0005, 16'd2, 24'd3, 32'd0);
        trig_q.push_back(4'h5); trig_q.push_back(4'h5); irq_q.push_back(ST_DONE);
        @(negedge clk); arm = 1'b1; a0 = cyc;
        @(negedge clk);
        total_cnt++; if (status_o !== ST_SETTLE || azmux_o !== 4'h5) $display("FAIL single_settle got st=%0d az=%h exp st=1 az=5", status_o, azmux_o); else pass_cnt++;
        wait_trig(20, ok);
        total_cnt++; if (!ok || cyc != a0 + 5) $display("FAIL single_trig1 got ok=%b cyc=%0d exp cyc=%0d", ok, cyc, a0 + 5); else pass_cnt++;
        t1 = cyc;
        repeat (10) @(negedge clk);
        valid = 1'b1;
        wait_trig(20, ok);
        valid = 1'b0;
        total_cnt++; if (!ok || cyc != t1 + 11) $display("FAIL single_trig2 got ok=%b cyc=%0d exp cyc=%0d", ok, cyc, t1 + 11); else pass_cnt++;
        t2 = cyc;
        repeat (10) @(negedge clk);
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        total_cnt++; if (status_o !== ST_DONE || complete_o !== 1'b1) $display("FAIL single_done got st=%0d cmp=%b exp st=4 cmp=1 (t2=%0d)", status_o, complete_o, t2); else pass_cnt++;
        total_cnt++; if (sample_count_o !== 16'd2 || ch_idx_o !== 2'd0 || azmux_o !== 4'h5) $display("FAIL single_final got sc=%0d ch=%0d az=%h exp sc=2 ch=0 az=5", sample_count_o, ch_idx_o, azmux_o); else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++; if (complete_o !== 1'b1 || irq_o !== 1'b0) $display("FAIL single_hold got cmp=%b irq=%b exp cmp=1 irq=0", complete_o, irq_o); else pass_cnt++;
        arm = 1'b0;
        @(negedge clk);
        total_cnt++; if (status_o !== ST_IDLE || complete_o !== 1'b0) $display("FAIL single_idle got st=%0d cmp=%b exp st=0 cmp=0", status_o, complete_o); else pass_cnt++;
        total_cnt++; if (trig_q.size() != 0 || irq_q.size() != 0) $display("FAIL single_leftover got trig=%0d irq=%0d exp 0 0", trig_q.size(), irq_q.size()); else pass_cnt++;
    endtask

    task automatic test_four_channels;
        logic [3:0] exp_code[4];
        exp_code = '{4'h1, 4'h2, 4'h4, 4'h8};
        set_params(2'd3, 16'h8421, 16'd1, 24'd0, 32'd0);
        for (int i = 0; i < 4; i++) trig_q.push_back(exp_code[i]);
        irq_q.push_back(ST_DONE);
        @(negedge clk); arm = 1'b1;
        for (int ch = 0; ch < 4; ch++) begin
            @(negedge clk);
            valid = 1'b0;
            total_cnt++; if (status_o !== ST_SETTLE || azmux_o !== exp_code[ch] || ch_idx_o !== 2'(ch)) $display("FAIL four_settle ch=%0d got st=%0d az=%h idx=%0d exp st=1 az=%h", ch, status_o, azmux_o, ch_idx_o, exp_code[ch]); else pass_cnt++;
            @(negedge clk);
            total_cnt++; if (trig_o !== 1'b1) $display("FAIL four_trig ch=%0d got=%b exp=1", ch, trig_o); else pass_cnt++;
            repeat (2) @(negedge clk);
            valid = 1'b1;
        end
        @(negedge clk);
        valid = 1'b0;
        total_cnt++; if (status_o !== ST_DONE || ch_idx_o !== 2'd3 || azmux_o !== 4'h8) $display("FAIL four_done got st=%0d idx=%0d az=%h exp st=4 idx=3 az=8", status_o, ch_idx_o, azmux_o); else pass_cnt++;
        arm = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (trig_q.size() != 0 || irq_q.size() != 0) $display("FAIL four_leftover got trig=%0d irq=%0d exp 0 0", trig_q.size(), irq_q.size()); else pass_cnt++;
    endtask

    task automatic test_timeout;
        int t;
        bit ok;
        set_params(2'd0, 16'h0005, 16'd1, 24'd0, 32'd20);
        trig_q.push_back(4'h5); irq_q.push_back(ST_ERR);
        @(negedge clk); arm = 1'b1;
        wait_trig(10, ok);
        t = cyc;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (status_o != ST_WAIT) break;
        end
        total_cnt++; if (!ok || status_o !== ST_ERR || cyc != t + 22) $display("FAIL tmo_err got ok=%b st=%0d cyc=%0d exp st=5 cyc=%0d", ok, status_o, cyc, t + 22); else pass_cnt++;
        repeat (5) @(negedge clk);
        total_cnt++; if (error_o !== 1'b1 || complete_o !== 1'b0) $display("FAIL tmo_flags got err=%b cmp=%b exp err=1 cmp=0", error_o, complete_o); else pass_cnt++;
        arm = 1'b0;
        @(negedge clk);
        total_cnt++; if (status_o !== ST_IDLE || error_o !== 1'b0) $display("FAIL tmo_idle got st=%0d err=%b exp st=0 err=0", status_o, error_o); else pass_cnt++;
        tmo = 32'd0;
        trig_q.push_back(4'h5);
        @(negedge clk); arm = 1'b1;
        wait_trig(10, ok);
        repeat (100) @(negedge clk);
        total_cnt++; if (!ok || status_o !== ST_WAIT || error_o !== 1'b0) $display("FAIL tmo_disabled got ok=%b st=%0d err=%b exp st=3 err=0", ok, status_o, error_o); else pass_cnt++;
        arm = 1'b0;
        @(negedge clk);
        total_cnt++; if (status_o !== ST_IDLE || irq_o !== 1'b0 || sample_count_o !== 16'd0 || azmux_o !== 4'h5) $display("FAIL abort_wait got st=%0d irq=%b sc=%0d az=%h exp st=0 irq=0 sc=0 az=5", status_o, irq_o, sample_count_o, azmux_o); else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++; if (trig_q.size() != 0 || irq_q.size() != 0) $display("FAIL tmo_leftover got trig=%0d irq=%0d exp 0 0", trig_q.size(), irq_q.size()); else pass_cnt++;
    endtask

    task automatic test_stale_valid;
        bit ok;
        set_params(2'd0, 16'h0003, 16'd1, 24'd2, 32'd0);
        valid = 1'b1;
        repeat (3) @(negedge clk);
        trig_q.push_back(4'h3); irq_q.push_back(ST_DONE);
        arm = 1'b1;
        wait_trig(20, ok);
        repeat (10) @(negedge clk);
        total_cnt++; if (!ok || status_o !== ST_WAIT) $display("FAIL stale_ignored got ok=%b st=%0d exp st=3", ok, status_o); else pass_cnt++;
        valid = 1'b0;
        repeat (2) @(negedge clk);
        valid = 1'b1;
        @(negedge clk);
        total_cnt++; if (status_o !== ST_DONE || sample_count_o !== 16'd1) $display("FAIL stale_done got st=%0d sc=%0d exp st=4 sc=1", status_o, sample_count_o); else pass_cnt++;
        valid = 1'b0;
        arm = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (trig_q.size() != 0 || irq_q.size() != 0) $display("FAIL stale_leftover got trig=%0d irq=%0d exp 0 0", trig_q.size(), irq_q.size()); else pass_cnt++;
    endtask

    task automatic test_reset_in_settle;
        set_params(2'd0, 16'h000a, 16'd1, 24'd10, 32'd0);
        @(negedge clk); arm = 1'b1;
        @(negedge clk);
        total_cnt++; if (status_o !== ST_SETTLE || azmux_o !== 4'ha) $display("FAIL rstmid_settle got st=%0d az=%h exp st=1 az=a", status_o, azmux_o); else pass_cnt++;
        reset = 1'b1;
        arm = 1'b0;
        @(negedge clk);
        total_cnt++; if (status_o !== 3'd0 || azmux_o !== 4'h0 || {trig_o, complete_o, irq_o, error_o} !== 4'b0000) $display("FAIL rstmid_outs got st=%0d az=%h flags=%b exp all 0", status_o, azmux_o, {trig_o, complete_o, irq_o, error_o}); else pass_cnt++;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        total_cnt++; if (status_o !== ST_IDLE || trig_q.size() != 0) $display("FAIL rstmid_idle got st=%0d exp st=0", status_o); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        bit ok;
        set_params(2'd0, 16'h0009, 16'd1, 24'd0, 32'd0);
        for (int run = 0; run < 2; run++) begin
            trig_q.push_back(4'h9); irq_q.push_back(ST_DONE);
            @(negedge clk); arm = 1'b1;
            wait_trig(10, ok);
            repeat (2) @(negedge clk);
            valid = 1'b1;
            @(negedge clk);
            valid = 1'b0;
            total_cnt++; if (!ok || status_o !== ST_DONE) $display("FAIL b2b_done run=%0d got ok=%b st=%0d exp st=4", run, ok, status_o); else pass_cnt++;
            if (run == 0) begin
                repeat (30) @(negedge clk);
                total_cnt++; if (status_o !== ST_DONE || complete_o !== 1'b1) $display("FAIL b2b_held got st=%0d cmp=%b exp st=4 cmp=1", status_o, complete_o); else pass_cnt++;
            end
            arm = 1'b0;
            @(negedge clk);
            total_cnt++; if (status_o !== ST_IDLE) $display("FAIL b2b_idle run=%0d got st=%0d exp st=0", run, status_o); else pass_cnt++;
        end
        total_cnt++; if (trig_q.size() != 0 || irq_q.size() != 0) $display("FAIL b2b_leftover got trig=%0d irq=%0d exp 0 0", trig_q.size(), irq_q.size()); else pass_cnt++;
    endtask

    task automatic test_zero_samples_coincident;
        bit ok;
        set_params(2'd1, 16'h0063, 16'd0, 24'd1, 32'd5);
        trig_q.push_back(4'h3); trig_q.push_back(4'h6); irq_q.push_back(ST_DONE);
        @(negedge clk); arm = 1'b1;
        for (int ch = 0; ch < 2; ch++) begin
            wait_trig(10, ok);
            repeat (6) @(negedge clk);
            total_cnt++; if (!ok || status_o !== ST_WAIT) $display("FAIL coin_wait ch=%0d got ok=%b st=%0d exp st=3", ch, ok, status_o); else pass_cnt++;
            valid = 1'b1;
            @(negedge clk);
            valid = 1'b0;
            total_cnt++; if (status_o !== ((ch == 0) ? ST_SETTLE : ST_DONE) || error_o !== 1'b0) $display("FAIL coin_next ch=%0d got st=%0d err=%b exp st=%0d err=0", ch, status_o, error_o, (ch == 0) ? 1 : 4); else pass_cnt++;
        end
        arm = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (trig_q.size() != 0 || irq_q.size() != 0) $display("FAIL coin_leftover got trig=%0d irq=%0d exp 0 0", trig_q.size(), irq_q.size()); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_four_channels();
        test_timeout();
        test_stale_valid();
        test_reset_in_settle();
        test_back_to_back();
        test_zero_samples_coincident();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
